// File: rtl/lsu_if.sv
// Shared types and the two port bundles of the load/store unit:
// the core-facing request/response side and the word-addressed memory bus.
package lsu_pkg;
   typedef enum logic [1:0] {
      MEM_NOP   = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2,
      MEM_RSVD  = 2'd3
   } mem_op_e;

   typedef enum logic [1:0] {
      RAM_MASK_B = 2'd0,
      RAM_MASK_H = 2'd1,
      RAM_MASK_W = 2'd2,
      RAM_MASK_X = 2'd3
   } ram_mask_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT_R = 2'd2,
      S_RESP   = 2'd3
   } lsu_state_e;
endpackage

// Core side: master is the execute stage, slave is the LSU.
interface lsu_core_if;
   import lsu_pkg::*;
   logic        req_valid;
   logic        req_ready;
   mem_op_e     mem_op;
   ram_mask_e   ram_mask;
   logic        unsigned_ld;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;

   modport master (
      output req_valid, mem_op, ram_mask, unsigned_ld, addr, wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, mem_op, ram_mask, unsigned_ld, addr, wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// Memory side: master is the LSU, slave is the RAM or peripheral.
interface lsu_mem_if;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );
   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one byte/half/word access from the core, checks
// alignment, runs it on a word-addressed bus with byte strobes, and returns
// formatted load data or a store completion as a one-cycle response pulse.
//
// Handshakes: a core request transfers on a cycle where req_valid and
// req_ready are both high; a bus request transfers on a cycle where mem_valid
// and mem_ready are both high, and mem_addr/mem_we/mem_wstrb/mem_wdata are
// held stable from mem_valid rising until that cycle. Read data is taken on
// the first mem_rvalid at or after the accepting cycle. resp_valid has no
// ready: it is high for exactly one cycle.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   lsu_core_if.slave  core,
   lsu_mem_if.master  mem,
   output lsu_state_e dbg_state
);

   lsu_state_e  state_q, state_d;
   mem_op_e     op_q, op_d;
   ram_mask_e   mask_q, mask_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic [16:0] cnt_inc;
   logic        timeout_hit;
   logic        is_store;
   logic [3:0]  lane_strb;
   logic [31:0] lane_wdata;

   // Half must be 2-byte aligned, word (and any unknown size) 4-byte aligned.
   function automatic logic misaligned(ram_mask_e m, logic [1:0] a);
      case (m)
         RAM_MASK_B: misaligned = 1'b0;
         RAM_MASK_H: misaligned = a[0];
         default:    misaligned = (a != 2'b00);
      endcase
   endfunction

   // Shift the addressed lane down to bit 0, then zero/sign extend.
   function automatic logic [31:0] format_load(ram_mask_e m, logic u,
                                               logic [1:0] k, logic [31:0] w);
      logic [31:0] s;
      s = w >> {k, 3'b000};
      case (m)
         RAM_MASK_B: format_load = u ? {24'd0, s[7:0]}   : {{24{s[7]}}, s[7:0]};
         RAM_MASK_H: format_load = u ? {16'd0, s[15:0]}  : {{16{s[15]}}, s[15:0]};
         default:    format_load = s;
      endcase
   endfunction

   assign is_store    = (op_q == MEM_STORE);
   assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
   assign timeout_hit = (cnt_inc == 17'(TIMEOUT));

   // Byte-lane strobes and replicated store data for the latched request.
   always_comb begin
      lane_strb  = 4'b1111;
      lane_wdata = wdata_q;
      case (mask_q)
         RAM_MASK_B: begin
            lane_strb  = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{wdata_q[7:0]}};
         end
         RAM_MASK_H: begin
            lane_strb  = 4'b0011 << addr_q[1:0];
            lane_wdata = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   // Next-state, request latching, wait counter and response capture.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mask_d  = mask_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (core.req_valid) begin
               op_d    = core.mem_op;
               mask_d  = core.ram_mask;
               uns_d   = core.unsigned_ld;
               addr_d  = core.addr;
               wdata_d = core.wdata;
               cnt_d   = 16'd0;
               if (misaligned(core.ram_mask, core.addr[1:0])) begin
                  state_d = S_RESP;
                  err_d   = 2'd1;
                  rdata_d = 32'd0;
               end else if (core.mem_op != MEM_LOAD && core.mem_op != MEM_STORE) begin
                  state_d = S_RESP;
                  err_d   = 2'd0;
                  rdata_d = 32'd0;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_inc[15:0];
            if (mem.mem_ready && is_store) begin
               state_d = S_RESP;
               err_d   = 2'd0;
               rdata_d = 32'd0;
            end else if (mem.mem_ready && mem.mem_rvalid) begin
               state_d = S_RESP;
               err_d   = 2'd0;
               rdata_d = format_load(mask_q, uns_q, addr_q[1:0], mem.mem_rdata);
            end else if (timeout_hit) begin
               // Covers an accepted load whose data would arrive too late too.
               state_d = S_RESP;
               err_d   = 2'd2;
               rdata_d = 32'd0;
            end else if (mem.mem_ready) begin
               state_d = S_WAIT_R;
            end
         end
         S_WAIT_R: begin
            cnt_d = cnt_inc[15:0];
            if (mem.mem_rvalid) begin
               state_d = S_RESP;
               err_d   = 2'd0;
               rdata_d = format_load(mask_q, uns_q, addr_q[1:0], mem.mem_rdata);
            end else if (timeout_hit) begin
               state_d = S_RESP;
               err_d   = 2'd2;
               rdata_d = 32'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= MEM_NOP;
         mask_q  <= RAM_MASK_B;
         uns_q   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 2'd0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mask_q  <= mask_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign core.req_ready  = (state_q == S_IDLE);
   assign core.resp_valid = (state_q == S_RESP);
   assign core.resp_rdata = rdata_q;
   assign core.resp_err   = err_q;

   assign mem.mem_valid = (state_q == S_ISSUE);
   assign mem.mem_we    = is_store;
   assign mem.mem_addr  = {addr_q[31:2], 2'b00};
   assign mem.mem_wstrb = is_store ? lane_strb : 4'b0000;
   assign mem.mem_wdata = lane_wdata;

   assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: two instances (long and short bus timeout) share one set of
// drivers; sel picks which one is observed. A byte-array model of memory
// predicts every response; the bench also plays the RAM on the bus side.
module tb_lsu;
   import lsu_pkg::*;

   localparam int TMO_A = 16;
   localparam int TMO_B = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic sel;

   // ---------------- shared drivers ----------------
   logic        req_valid;
   mem_op_e     mem_op;
   ram_mask_e   ram_mask;
   logic        unsigned_ld;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   lsu_core_if core_a ();
   lsu_mem_if  mem_a ();
   lsu_core_if core_b ();
   lsu_mem_if  mem_b ();
   lsu_state_e dbg_a, dbg_b;

   assign core_a.req_valid   = req_valid;
   assign core_a.mem_op      = mem_op;
   assign core_a.ram_mask    = ram_mask;
   assign core_a.unsigned_ld = unsigned_ld;
   assign core_a.addr        = addr;
   assign core_a.wdata       = wdata;
   assign mem_a.mem_ready    = mem_ready;
   assign mem_a.mem_rvalid   = mem_rvalid;
   assign mem_a.mem_rdata    = mem_rdata;
   assign core_b.req_valid   = req_valid;
   assign core_b.mem_op      = mem_op;
   assign core_b.ram_mask    = ram_mask;
   assign core_b.unsigned_ld = unsigned_ld;
   assign core_b.addr        = addr;
   assign core_b.wdata       = wdata;
   assign mem_b.mem_ready    = mem_ready;
   assign mem_b.mem_rvalid   = mem_rvalid;
   assign mem_b.mem_rdata    = mem_rdata;

   lsu #(.TIMEOUT(TMO_A)) dut_a (.clk(clk), .rst_n(rst_n), .core(core_a), .mem(mem_a), .dbg_state(dbg_a));
   lsu #(.TIMEOUT(TMO_B)) dut_b (.clk(clk), .rst_n(rst_n), .core(core_b), .mem(mem_b), .dbg_state(dbg_b));

   // Observed outputs of the selected instance.
   logic        o_req_ready, o_resp_valid, o_mem_valid, o_mem_we;
   logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
   logic [1:0]  o_resp_err;
   logic [3:0]  o_mem_wstrb;
   lsu_state_e  o_dbg;
   assign o_req_ready  = sel ? core_b.req_ready  : core_a.req_ready;
   assign o_resp_valid = sel ? core_b.resp_valid : core_a.resp_valid;
   assign o_resp_rdata = sel ? core_b.resp_rdata : core_a.resp_rdata;
   assign o_resp_err   = sel ? core_b.resp_err   : core_a.resp_err;
   assign o_mem_valid  = sel ? mem_b.mem_valid   : mem_a.mem_valid;
   assign o_mem_we     = sel ? mem_b.mem_we      : mem_a.mem_we;
   assign o_mem_addr   = sel ? mem_b.mem_addr    : mem_a.mem_addr;
   assign o_mem_wstrb  = sel ? mem_b.mem_wstrb   : mem_a.mem_wstrb;
   assign o_mem_wdata  = sel ? mem_b.mem_wdata   : mem_a.mem_wdata;
   assign o_dbg        = sel ? dbg_b             : dbg_a;

   // ---------------- reference model / scoreboard ----------------
   logic [7:0]  ref_mem [0:255];   // byte-array view predicted from the rules
   logic [31:0] bus_mem [0:63];    // word RAM written through the DUT's strobes
   logic [33:0] exp_q[$];          // {err, rdata}
   logic [31:0] last_rdata, last_wdata;
   logic [1:0]  last_err;
   logic [3:0]  last_wstrb;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
      bus_mem[a[7:2]] = v;
      for (int i = 0; i < 4; i++) ref_mem[int'({a[7:2], 2'b00}) + i] = v[8*i +: 8];
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_req_ready"}, o_req_ready, 1);
      chk({p, "_resp_valid"}, o_resp_valid, 0);
      chk({p, "_resp_rdata"}, o_resp_rdata, 0);
      chk({p, "_resp_err"}, o_resp_err, 0);
      chk({p, "_mem_valid"}, o_mem_valid, 0);
      chk({p, "_mem_we"}, o_mem_we, 0);
      chk({p, "_mem_addr"}, o_mem_addr, 0);
      chk({p, "_mem_wstrb"}, o_mem_wstrb, 0);
      chk({p, "_mem_wdata"}, o_mem_wdata, 0);
      chk({p, "_state"}, o_dbg, S_IDLE);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- driver: one request plus the bus responder ----------------
   // rdy_dly: cycles of mem_ready low before accepting; rv_dly: cycles from the
   // accepting cycle to mem_rvalid (0 = same cycle).
   task automatic run_txn(input logic [1:0] op, input logic [1:0] mask, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rdy_dly, input int rv_dly);
      int size, tmo, need, lat_exp, n, issue_n, rdy_cyc, k;
      bit is_ld, is_st, mis, bus_exp, saw_valid, done;
      logic [33:0] e, got;
      logic [31:0] val, msk, wdat_e;
      logic [3:0]  strb_e;
      tmo   = sel ? TMO_B : TMO_A;
      is_ld = (op == 2'd1);
      is_st = (op == 2'd2);
      size  = (mask == 2'd0) ? 1 : (mask == 2'd1) ? 2 : 4;
      k     = int'(a[1:0]);
      mis   = (k % size) != 0;
      strb_e = 4'(((1 << size) - 1) << k);
      wdat_e = (size == 1) ? {24'd0, wd[7:0]} * 32'h01010101 :
               (size == 2) ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
      bus_exp = 1'b0;
      if (mis) begin
         e = {2'd1, 32'd0}; lat_exp = 1;
      end else if (!is_ld && !is_st) begin
         e = 34'd0; lat_exp = 1;
      end else begin
         bus_exp = 1'b1;
         need = rdy_dly + 1 + (is_ld ? rv_dly : 0);
         if (need > tmo) begin
            e = {2'd2, 32'd0}; lat_exp = tmo + 1;
         end else begin
            lat_exp = need + 1;
            if (is_st) begin
               e = 34'd0;
               for (int i = 0; i < size; i++) ref_mem[int'(a[7:0]) + i] = wd[8*i +: 8];
            end else begin
               val = 32'd0;
               for (int i = 0; i < size; i++) val |= 32'(ref_mem[int'(a[7:0]) + i]) << (8*i);
               if (size < 4 && !uns) begin
                  msk = (32'd1 << (8*size)) - 32'd1;
                  if (val[8*size-1]) val |= ~msk;
               end
               e = {2'd0, val};
            end
         end
      end
      exp_q.push_back(e);

      @(negedge clk);
      req_valid = 1'b1; mem_op = mem_op_e'(op); ram_mask = ram_mask_e'(mask);
      unsigned_ld = uns; addr = a; wdata = wd;
      chk("req_ready", o_req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1; issue_n = 0; rdy_cyc = 0; done = 1'b0; saw_valid = 1'b0;
      while (!done && n <= 40) begin
         mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
         if (o_resp_valid) begin
            got = {o_resp_err, o_resp_rdata};
            e = exp_q.pop_front();
            chk("resp", got, e);
            chk("latency", n, lat_exp);
            chk("mem_valid_in_resp", o_mem_valid, 0);
            last_rdata = o_resp_rdata; last_err = o_resp_err;
            done = 1'b1;
         end else begin
            if (o_mem_valid) begin
               saw_valid = 1'b1;
               chk("mem_addr", o_mem_addr, {a[31:2], 2'b00});
               chk("mem_we", o_mem_we, is_st);
               chk("mem_wstrb", o_mem_wstrb, is_st ? strb_e : 4'd0);
               if (is_st) chk("mem_wdata", o_mem_wdata, wdat_e);
               last_wstrb = o_mem_wstrb; last_wdata = o_mem_wdata;
               if (issue_n == rdy_dly) begin
                  mem_ready = 1'b1; rdy_cyc = n;
                  if (is_st)
                     for (int l = 0; l < 4; l++)
                        if (o_mem_wstrb[l]) bus_mem[a[7:2]][8*l +: 8] = o_mem_wdata[8*l +: 8];
               end
               issue_n++;
            end
            if (is_ld && rdy_cyc > 0 && n == rdy_cyc + rv_dly) begin
               mem_rvalid = 1'b1; mem_rdata = bus_mem[a[7:2]];
            end
            @(negedge clk);
            n++;
         end
      end
      if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
      chk("resp_seen", done, 1);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      chk("bus_used", saw_valid, bus_exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] r_op, r_mask;
      int r;
      sel = 1'b0; rst_n = 1'b0;
      req_valid = 1'b0; mem_op = MEM_NOP; ram_mask = RAM_MASK_B; unsigned_ld = 1'b0;
      addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      for (int i = 0; i < 64; i++) poke_word(32'(i * 4), $urandom());
      repeat (3) @(negedge clk);
      chk_reset_vals("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_vals("after_reset");

      // Word store then load back.
      run_txn(2'd2, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0);
      chk("sw_wstrb", last_wstrb, 4'hF);
      chk("sw_wdata", last_wdata, 32'hDEADBEEF);
      chk("sw_err", last_err, 0);
      run_txn(2'd1, 2'd2, 1'b0, 32'h100, 32'd0, 0, 0);
      chk("lw_rdata", last_rdata, 32'hDEADBEEF);

      // Byte store to the top lane, byte loads with both extensions.
      run_txn(2'd2, 2'd0, 1'b0, 32'h103, 32'h0000005A, 0, 0);
      chk("sb_wstrb", last_wstrb, 4'b1000);
      chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
      poke_word(32'h100, 32'h80000000);
      run_txn(2'd1, 2'd0, 1'b0, 32'h103, 32'd0, 0, 0);
      chk("lb_rdata", last_rdata, 32'hFFFFFF80);
      run_txn(2'd1, 2'd0, 1'b1, 32'h103, 32'd0, 0, 0);
      chk("lbu_rdata", last_rdata, 32'h00000080);

      // Upper half loads and store.
      poke_word(32'h100, 32'h80011234);
      run_txn(2'd1, 2'd1, 1'b0, 32'h102, 32'd0, 0, 0);
      chk("lh_rdata", last_rdata, 32'hFFFF8001);
      run_txn(2'd1, 2'd1, 1'b1, 32'h102, 32'd0, 0, 0);
      chk("lhu_rdata", last_rdata, 32'h00008001);
      run_txn(2'd2, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 1, 0);
      chk("sh_wstrb", last_wstrb, 4'b1100);
      chk("sh_wdata", last_wdata, 32'hABCDABCD);

      // Misaligned accesses and a no-op.
      run_txn(2'd1, 2'd2, 1'b0, 32'h101, 32'd0, 0, 0);
      chk("lw_mis_err", last_err, 1);
      chk("lw_mis_rdata", last_rdata, 0);
      run_txn(2'd1, 2'd1, 1'b0, 32'h103, 32'd0, 0, 0);
      chk("lh_mis_err", last_err, 1);
      run_txn(2'd0, 2'd2, 1'b0, 32'h44, 32'h11111111, 0, 0);
      chk("nop_rdata", last_rdata, 0);

      // Slow bus: ready after 3 cycles, data 2 cycles after that.
      poke_word(32'h40, 32'hCAFEF00D);
      run_txn(2'd1, 2'd2, 1'b0, 32'h40, 32'd0, 3, 2);
      chk("slow_lw_rdata", last_rdata, 32'hCAFEF00D);

      // Randomized mix against the model.
      for (int t = 0; t < 80; t++) begin
         r = $urandom_range(0, 9);
         r_op   = (r == 0) ? (($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0) : (r < 5) ? 2'd1 : 2'd2;
         r_mask = 2'($urandom_range(0, 3));
         run_txn(r_op, r_mask, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                 ($urandom_range(0, 14) == 0) ? 20 : $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Asynchronous reset while waiting for read data.
      poke_word(32'h60, 32'h13579BDF);
      run_txn(2'd1, 2'd2, 1'b0, 32'h60, 32'd0, 0, 0);
      chk("pre_reset_ld", last_rdata, 32'h13579BDF);
      @(negedge clk);
      req_valid = 1'b1; mem_op = MEM_LOAD; ram_mask = RAM_MASK_W; unsigned_ld = 1'b0; addr = 32'h64;
      @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b1;
      chk("rst_issue_state", o_dbg, S_ISSUE);
      @(negedge clk);
      mem_ready = 1'b0;
      chk("rst_wait_state", o_dbg, S_WAIT_R);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_resp", o_resp_valid, 0);
      end
      mem_rvalid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", o_req_ready, 1);
      chk("rst_no_resp_after", o_resp_valid, 0);

      // Short-timeout instance: stuck bus, late data, recovery, boundaries.
      sel = 1'b1;
      reset_dut();
      run_txn(2'd1, 2'd2, 1'b0, 32'h80, 32'd0, 99, 0);
      chk("tmo_err", last_err, 2);
      chk("tmo_rdata", last_rdata, 0);
      repeat (3) begin
         @(negedge clk);
         mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
         chk("late_mem_valid", o_mem_valid, 0);
         chk("late_no_resp", o_resp_valid, 0);
         chk("late_err_held", o_resp_err, 2);
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("late_no_resp_end", o_resp_valid, 0);
      run_txn(2'd1, 2'd2, 1'b0, 32'h80, 32'd0, 0, 0);
      run_txn(2'd2, 2'd0, 1'b0, 32'h81, 32'h000000C3, 3, 0);
      run_txn(2'd1, 2'd1, 1'b0, 32'h80, 32'd0, 1, 2);
      run_txn(2'd1, 2'd1, 1'b1, 32'h80, 32'd0, 1, 3);
      chk("tmo_in_wait_err", last_err, 2);
      run_txn(2'd2, 2'd2, 1'b0, 32'h84, 32'h0BADF00D, 4, 0);
      chk("tmo_store_err", last_err, 2);
      run_txn(2'd1, 2'd2, 1'b0, 32'h84, 32'd0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time bound on the whole run.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that sits between the RV32I execute stage and the data memory port. It takes one byte, half or word load/store request at a time from the core and checks alignment. It drives a word-addressed bus with byte strobes and a valid/ready handshake, then returns formatted (sign- or zero-extended) load data or a store completion. It is the initiator for the data RAM, replacing direct combinational access so that multi-cycle memories and peripherals can be attached.

## Interface
- TIMEOUT, 255: max cycles spent waiting on the bus (ISSUE+WAIT_R) before an error response; 1..65535.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- mem_op  in  mem_op_e  MEM_LOAD / MEM_STORE; any other value = no-op
- ram_mask  in  ram_mask_e  RAM_MASK_B / RAM_MASK_H / RAM_MASK_W (other values treated as W)
- unsigned_ld  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  32  formatted load data (0 for stores/no-ops/errors)
- resp_err  out  2  0 ok, 1 misaligned, 2 bus timeout
- mem_valid  out  1  bus request valid
- mem_ready  in  1  bus accepts request
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_wstrb  out  4  byte-lane enables (0000 on reads)
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- States: IDLE, ISSUE, WAIT_R, RESP. req_ready = (state==IDLE).
- IDLE: on req_valid, latch mem_op, ram_mask, unsigned_ld, addr, wdata.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): go to RESP with err=1, no bus activity.
  - No-op mem_op: go to RESP with err=0 and rdata=0.
  - Otherwise: go to ISSUE and clear the timeout counter.
- ISSUE: mem_valid=1, with mem_addr/mem_we/mem_wstrb/mem_wdata held stable until mem_ready.
  - Store + mem_ready: go to RESP.
  - Load + mem_ready: go to RESP if mem_rvalid in the same cycle (latch data); else go to WAIT_R.
- WAIT_R: wait for mem_rvalid, latch mem_rdata, go to RESP. mem_rvalid in IDLE/RESP is ignored.
- Timeout: the counter increments each cycle in ISSUE/WAIT_R. If it reaches TIMEOUT without the exit condition, go to RESP with err=2 and drop mem_valid. A late mem_rvalid is then ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no back-pressure; the core must sample it.
- Store lanes, k=addr[1:0]:
  - B: wstrb=0001<<k, wdata={4{wdata[7:0]}}.
  - H: wstrb=0011<<k, wdata={2{wdata[15:0]}}.
  - W: wstrb=1111, wdata=wdata.
- Load format: s = mem_rdata >> (8*k).
  - B: take s[7:0] and extend to 32 bits per unsigned_ld.
  - H: take s[15:0] and extend to 32 bits per unsigned_ld.
  - W: take s.
- Address/data are little-endian, consistent with the byte-array RAM.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, counter=0.
- Reset is asynchronous at any time, including mid-transaction. The transaction is abandoned with no response, and mem_valid drops immediately.
- Accept at cycle T. mem_valid rises at T+1.
- Zero-wait bus (ready at T+1): a store has resp_valid at T+2. A load with same-cycle rvalid has resp_valid at T+2.
- Each wait cycle on ready or rvalid adds one cycle.
- Misaligned/no-op: resp_valid at T+1.
- Next accept: earliest the cycle after resp_valid (back-to-back store throughput = 1 per 3 cycles at zero wait).
- resp_rdata/resp_err are valid only while resp_valid. They are held registered until the next response.
- Timeout: resp_valid with err=2 at T+1+TIMEOUT when the bus never responds.

## Test plan
- SW 0xDEADBEEF at 0x100, ready immediately: mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, resp_valid at T+2 with err=0. Then LW 0x100 with rvalid same cycle: resp_rdata=0xDEADBEEF.
- SB 0x5A at 0x103: wstrb=1000, wdata=0x5A5A5A5A. LB 0x103 with mem_rdata=0x80000000 gives 0xFFFFFF80; LBU gives 0x00000080.
- LH 0x102, mem_rdata=0x8001_1234: LH gives 0xFFFF8001, LHU gives 0x00008001. SH 0xABCD at 0x102 gives wstrb=1100, wdata=0xABCDABCD.
- LW at 0x101 and LH at 0x103: no mem_valid, resp_valid at T+1 with err=1, rdata=0.
- mem_ready low for 3 cycles, then rvalid 2 cycles later: mem_* stays stable while waiting, and the single resp_valid carries the correct data. With TIMEOUT=4 and mem_ready stuck low: err=2 at T+5, mem_valid=0 afterwards, and a late rvalid is ignored.
- rst_n asserted during WAIT_R: outputs go to reset values asynchronously, no resp_valid, and req_ready=1 after release.
